sd_cmd_seq: RTL and testbench
=============================

# sd_cmd_seq

SD-card SPI-mode command sequencer sitting between the card-driver top level and the SPI byte engine. Accepts one command request (index + 32-bit argument), frames it into the 6-byte SD command token, feeds the bytes one at a time to the byte engine, then clocks 0xFF fill bytes until an R1 response arrives or a timeout expires. Owns chip-select for the card and reports the R1 byte, or a timeout, back to the requester.

## Interface
- NCR_MAX, 8: max fill bytes sent while polling for R1 before timeout (1..255)
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- CMD_STB  in  1  one-cycle command request
- CMD_IDX  in  6  command index, sampled with CMD_STB
- CMD_ARG  in  32  command argument, sampled with CMD_STB
- CMD_ACK  out  1  one-cycle pulse, request accepted
- BUSY  out  1  high from acceptance until RSP_STB cycle inclusive
- RSP_STB  out  1  one-cycle pulse, transaction finished
- RSP_DATA  out  8  R1 byte, valid with RSP_STB (0xFF on timeout)
- RSP_TO  out  1  timeout flag, valid with RSP_STB
- CS  out  1  card chip-select, active low
- SPI_W_STB  out  1  one-cycle byte-send strobe to byte engine
- SPI_W_DATA  out  8  byte to send, valid with SPI_W_STB
- SPI_W_ACK  in  1  one-cycle pulse, byte engine finished shifting
- SPI_R_STB  in  1  one-cycle pulse, byte received
- SPI_R_DATA  in  8  received byte, valid with SPI_R_STB

## Operation
- Reset values: CS=1, BUSY=0, CMD_ACK=0, RSP_STB=0, RSP_DATA=0x00, RSP_TO=0, SPI_W_STB=0, SPI_W_DATA=0xFF; state IDLE.
- States: IDLE, LOAD, SEND, POLL, TAIL, DONE.
- IDLE: on CMD_STB latch {0b01, CMD_IDX, CMD_ARG} into a 40-bit frame, pulse CMD_ACK, BUSY=1, CS=0 -> LOAD. CMD_STB outside IDLE is ignored (no CMD_ACK).
- LOAD: compute CRC byte (see Configuration), byte counter=0 -> SEND.
- SEND: issue frame bytes MSB-first (byte 0 = 0x40|CMD_IDX, bytes 1-4 = CMD_ARG[31:24]..[7:0], byte 5 = CRC byte). One SPI_W_STB per byte; next strobe only after SPI_W_ACK for the previous byte. After ACK of byte 5 -> POLL with fill counter=0.
- POLL: send 0xFF, wait SPI_W_ACK, increment fill counter. Any SPI_R_STB with SPI_R_DATA[7]=0 captures R1 and marks response found. SPI_R_STB with bit7=1 is ignored. After each fill ACK: if response found -> TAIL; else if counter==NCR_MAX -> TAIL with timeout set (RSP_DATA=0xFF); else next fill byte.
- SPI_R_STB during IDLE/LOAD/SEND/TAIL is ignored.
- TAIL: send one 0xFF with CS still low (Ncs gap); on its ACK raise CS -> DONE.
- DONE: pulse RSP_STB with RSP_DATA/RSP_TO held until next acceptance; BUSY drops the following cycle -> IDLE.
- RST mid-transaction: abandon immediately, all outputs to reset values, CS=1 next edge; no RSP_STB.

## Timing
- CMD_STB at edge N -> CMD_ACK, BUSY, CS=0 registered at N+1; first SPI_W_STB at N+3.
- Inter-byte: SPI_W_ACK seen at edge M -> next SPI_W_STB at M+1.
- SPI_R_STB and SPI_W_ACK in the same cycle in POLL: response captured and fill byte counted complete in that cycle; goes TAIL even if counter reaches NCR_MAX (response wins over timeout).
- Last TAIL ACK at edge K -> CS=1 at K+1, RSP_STB at K+1, BUSY=0 at K+2; new CMD_STB accepted from K+2.
- SPI_W_STB is never high two consecutive cycles; SPI_W_DATA stable from strobe until ACK.

## Configuration
- SD_CRC7_EN defined: CRC byte = {CRC7(frame[39:0]), 1}, polynomial x^7+x^3+1, init 0, computed serially over 40 bits in LOAD (LOAD lasts 40 cycles; first SPI_W_STB then at N+42).
- Not defined: LOAD is one cycle; CRC byte = 0x95 for CMD0, 0x87 for CMD8, 0x01 otherwise.

## Test plan
- CMD0 arg 0x00000000, engine model returns R1 0x01 on 2nd fill -> bytes 40 00 00 00 00 95 FF FF FF, RSP_DATA=0x01, RSP_TO=0, CS low throughout, high after TAIL.
- CMD8 arg 0x000001AA -> bytes 48 00 00 01 AA 87; both macro settings give 0x87.
- No response, NCR_MAX=8 -> exactly 8 fill bytes + 1 tail, RSP_DATA=0xFF, RSP_TO=1.
- R1 0x05 coincident with 8th fill ACK -> RSP_DATA=0x05, RSP_TO=0.
- CMD_STB while BUSY -> no CMD_ACK, frame of first command unaltered; R_STB with 0xFF in POLL ignored.
- RST asserted during byte 3 of SEND -> CS=1, SPI_W_STB=0 next edge, no RSP_STB; subsequent CMD0 completes normally.

Source files
------------

// File: rtl/sd_cmd_seq_if.sv
// sd_cmd_seq_if: command-side and SPI-byte-engine-side signals of sd_cmd_seq.
// The sequencer connects through the slave modport; requester/engine use master.
interface sd_cmd_seq_if;
    logic        CMD_STB;
    logic [5:0]  CMD_IDX;
    logic [31:0] CMD_ARG;
    logic        CMD_ACK;
    logic        BUSY;
    logic        RSP_STB;
    logic [7:0]  RSP_DATA;
    logic        RSP_TO;
    logic        CS;
    logic        SPI_W_STB;
    logic [7:0]  SPI_W_DATA;
    logic        SPI_W_ACK;
    logic        SPI_R_STB;
    logic [7:0]  SPI_R_DATA;

    modport master (
        output CMD_STB, CMD_IDX, CMD_ARG,
        output SPI_W_ACK, SPI_R_STB, SPI_R_DATA,
        input  CMD_ACK, BUSY, RSP_STB, RSP_DATA, RSP_TO,
        input  CS, SPI_W_STB, SPI_W_DATA
    );

    modport slave (
        input  CMD_STB, CMD_IDX, CMD_ARG,
        input  SPI_W_ACK, SPI_R_STB, SPI_R_DATA,
        output CMD_ACK, BUSY, RSP_STB, RSP_DATA, RSP_TO,
        output CS, SPI_W_STB, SPI_W_DATA
    );
endinterface

// File: rtl/sd_cmd_seq.sv
// sd_cmd_seq: SD SPI-mode command sequencer (frame, send, poll R1, tail byte).
// Define SD_CRC7_EN to compute the CRC7 serially instead of fixed CRC bytes.
module sd_cmd_seq #(
    parameter int NCR_MAX = 8
) (
    input logic         CLK,
    input logic         RST,
    sd_cmd_seq_if.slave bus
);

    typedef enum logic [2:0] {IDLE, LOAD, SEND, POLL, TAIL, DONE} state_t;

    state_t      state;
    state_t      nxt;
    logic [39:0] frame;
    logic [2:0]  byte_cnt;
    logic [2:0]  sel;
    logic [7:0]  fill_cnt;
    logic [7:0]  r1;
    logic [7:0]  crc_byte;
    logic [7:0]  frame_byte;
    logic [7:0]  issue_byte;
    logic        pending;
    logic        found;
    logic        timeout;
    logic        accept;
    logic        ack_ok;
    logic        r1_hit;
    logic        found_now;
    logic        fill_last;
    logic        load_done;
    logic        issue;
    logic        finish;

    // An ACK arriving while our strobe is still high is not for a finished byte.
    assign ack_ok    = bus.SPI_W_ACK && pending && !bus.SPI_W_STB;
    assign r1_hit    = bus.SPI_R_STB && !bus.SPI_R_DATA[7];
    assign found_now = found || r1_hit;
    assign fill_last = ({1'b0, fill_cnt} + 9'd1) == 9'(NCR_MAX);

`ifdef SD_CRC7_EN
    logic [6:0] crc7;
    logic [5:0] bit_cnt;
    logic       crc_fb;

    assign crc_fb    = frame[6'd39 - bit_cnt] ^ crc7[6];
    assign load_done = (bit_cnt == 6'd39);
    assign crc_byte  = {crc7, 1'b1};

    always_ff @(posedge CLK) begin
        if (RST) begin
            crc7    <= '0;
            bit_cnt <= '0;
        end else if (accept) begin
            crc7    <= '0;
            bit_cnt <= '0;
        end else if (state == LOAD) begin
            crc7    <= {crc7[5:0], 1'b0} ^ (crc_fb ? 7'h09 : 7'h00);
            bit_cnt <= bit_cnt + 6'd1;
        end
    end
`else
    assign load_done = 1'b1;

    always_comb begin
        unique case (frame[37:32])
            6'd0:    crc_byte = 8'h95;
            6'd8:    crc_byte = 8'h87;
            default: crc_byte = 8'h01;
        endcase
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (bus.CMD_STB) nxt = LOAD;
            LOAD:    if (load_done) nxt = SEND;
            SEND:    if (ack_ok && byte_cnt == 3'd5) nxt = POLL;
            POLL:    if (ack_ok && (found_now || fill_last)) nxt = TAIL;
            TAIL:    if (ack_ok) nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // While a byte is pending, its ACK launches the following byte at once.
    always_comb begin
        accept = (state == IDLE) && bus.CMD_STB;
        finish = (state == TAIL) && ack_ok;
        issue  = ((state == SEND) && (!pending || ack_ok))
              || ((state == POLL) && ack_ok);
        sel    = pending ? byte_cnt + 3'd1 : byte_cnt;
        unique case (sel)
            3'd0:    frame_byte = frame[39:32];
            3'd1:    frame_byte = frame[31:24];
            3'd2:    frame_byte = frame[23:16];
            3'd3:    frame_byte = frame[15:8];
            3'd4:    frame_byte = frame[7:0];
            3'd5:    frame_byte = crc_byte;
            default: frame_byte = 8'hFF;
        endcase
        issue_byte = (state == SEND) ? frame_byte : 8'hFF;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            frame          <= '0;
            byte_cnt       <= '0;
            fill_cnt       <= '0;
            pending        <= 1'b0;
            found          <= 1'b0;
            timeout        <= 1'b0;
            r1             <= '0;
            bus.CMD_ACK    <= 1'b0;
            bus.BUSY       <= 1'b0;
            bus.RSP_STB    <= 1'b0;
            bus.RSP_DATA   <= 8'h00;
            bus.RSP_TO     <= 1'b0;
            bus.CS         <= 1'b1;
            bus.SPI_W_STB  <= 1'b0;
            bus.SPI_W_DATA <= 8'hFF;
        end else begin
            bus.CMD_ACK   <= accept;
            bus.RSP_STB   <= finish;
            bus.SPI_W_STB <= issue;
            if (issue) begin
                bus.SPI_W_DATA <= issue_byte;
                pending        <= 1'b1;
            end else if (ack_ok) begin
                pending <= 1'b0;
            end
            if (accept) begin
                frame    <= {2'b01, bus.CMD_IDX, bus.CMD_ARG};
                bus.BUSY <= 1'b1;
                bus.CS   <= 1'b0;
                byte_cnt <= '0;
                fill_cnt <= '0;
                found    <= 1'b0;
                timeout  <= 1'b0;
            end
            if (state == SEND && ack_ok) byte_cnt <= byte_cnt + 3'd1;
            // A coincident R1 and final fill ACK resolves as a response.
            if (state == POLL) begin
                if (r1_hit && !found) begin
                    r1    <= bus.SPI_R_DATA;
                    found <= 1'b1;
                end
                if (ack_ok) begin
                    fill_cnt <= fill_cnt + 8'd1;
                    timeout  <= !found_now;
                end
            end
            if (finish) begin
                bus.CS       <= 1'b1;
                bus.RSP_DATA <= timeout ? 8'hFF : r1;
                bus.RSP_TO   <= timeout;
            end
            if (state == DONE) bus.BUSY <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sd_cmd_seq.sv
// tb_sd_cmd_seq: directed bench for sd_cmd_seq with a byte-engine model
// and a scoreboard of expected SPI bytes.
module tb_sd_cmd_seq;

    localparam int NCR = 8;
`ifdef SD_CRC7_EN
    localparam int FIRST = 41;
`else
    localparam int FIRST = 2;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    sd_cmd_seq_if bus();

    sd_cmd_seq #(.NCR_MAX(NCR)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0] q[$];
    int         eng_cnt = 0;
    int         bidx = 0;
    int         cur_b = 0;
    bit         resp_hit = 0;
    int         resp_at = 0;
    logic [7:0] resp_val = 8'h00;
    bit         early = 0;
    bit         junk = 0;
    bit         prev_stb = 0;
    logic [7:0] last_b = 8'hFF;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] crc_of(input logic [5:0] idx,
                                           input logic [31:0] arg);
`ifdef SD_CRC7_EN
        logic [39:0] f;
        logic [6:0]  c;
        f = {2'b01, idx, arg};
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            bit fb;
            fb = f[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return {c, 1'b1};
`else
        if (idx == 6'd0) return 8'h95;
        if (idx == 6'd8) return 8'h87;
        return 8'h01;
`endif
    endfunction

    // Byte-engine model and scoreboard consumer.
    always @(negedge CLK) begin
        logic [7:0] exp_b;
        bus.SPI_W_ACK  = 1'b0;
        bus.SPI_R_STB  = 1'b0;
        bus.SPI_R_DATA = 8'hFF;
        if (bus.CMD_ACK) bidx = 0;
        if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 2 && junk) begin
                bus.SPI_R_STB  = 1'b1;
                bus.SPI_R_DATA = (cur_b < 6) ? 8'h00 : 8'hFF;
            end
            if (eng_cnt == 1 && resp_hit && early) begin
                bus.SPI_R_STB  = 1'b1;
                bus.SPI_R_DATA = resp_val;
            end
            if (eng_cnt == 0) begin
                bus.SPI_W_ACK = 1'b1;
                check("w_hold", bus.SPI_W_DATA, last_b);
                if (resp_hit && !early) begin
                    bus.SPI_R_STB  = 1'b1;
                    bus.SPI_R_DATA = resp_val;
                end
            end
        end
        if (bus.SPI_W_STB) begin
            check("w_consec", prev_stb, 0);
            check("cs_low", bus.CS, 0);
            check("w_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
                exp_b = q.pop_front();
                check("w_data", bus.SPI_W_DATA, exp_b);
            end
            last_b   = bus.SPI_W_DATA;
            cur_b    = bidx;
            resp_hit = (resp_at != 0) && (bidx - 5 == resp_at);
            eng_cnt  = 3;
            bidx++;
        end
        prev_stb = bus.SPI_W_STB;
    end

    task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg,
                          input logic [7:0] crc, input int r_at,
                          input logic [7:0] r_val, input bit r_early,
                          input bit jk, input bit poke, input int rst_byte);
        int   nfill;
        bit   to;
        bit   got;
        logic [7:0] exp_d;
        to    = (r_at == 0) || (r_at > NCR);
        nfill = to ? NCR : r_at;
        exp_d = to ? 8'hFF : r_val;
        q.push_back({2'b01, idx});
        q.push_back(arg[31:24]);
        q.push_back(arg[23:16]);
        q.push_back(arg[15:8]);
        q.push_back(arg[7:0]);
        q.push_back(crc);
        for (int i = 0; i <= nfill; i++) q.push_back(8'hFF);
        resp_at  = r_at;
        resp_val = r_val;
        early    = r_early;
        junk     = jk;

        @(negedge CLK);
        bus.CMD_STB = 1'b1;
        bus.CMD_IDX = idx;
        bus.CMD_ARG = arg;
        @(negedge CLK);
        bus.CMD_STB = 1'b0;
        check("cmd_ack", bus.CMD_ACK, 1);
        check("busy_on", bus.BUSY, 1);
        check("cs_on", bus.CS, 0);
        for (int k = 1; k <= FIRST; k++) begin
            @(negedge CLK);
            if (k == FIRST - 1) check("lat_pre", bus.SPI_W_STB, 0);
            if (k == FIRST) check("lat_first", bus.SPI_W_STB, 1);
        end
        if (poke) begin
            @(negedge CLK);
            bus.CMD_STB = 1'b1;
            bus.CMD_IDX = 6'd5;
            bus.CMD_ARG = 32'hFFFF_FFFF;
            @(negedge CLK);
            bus.CMD_STB = 1'b0;
            check("busy_noack", bus.CMD_ACK, 0);
        end
        if (rst_byte > 0) begin
            got = 0;
            for (int k = 0; k < 200; k++) begin
                @(posedge CLK);
                if (bidx >= rst_byte + 1) begin
                    got = 1;
                    break;
                end
            end
            check("rst_reach", got, 1);
            @(negedge CLK);
            RST = 1'b1;
            @(posedge CLK);
            #1;
            q.delete();
            eng_cnt  = 0;
            resp_hit = 0;
            @(negedge CLK);
            RST = 1'b0;
            check("rst_cs", bus.CS, 1);
            check("rst_wstb", bus.SPI_W_STB, 0);
            check("rst_busy", bus.BUSY, 0);
            check("rst_rdata", bus.RSP_DATA, 8'h00);
            got = 0;
            for (int k = 0; k < 30; k++) begin
                @(negedge CLK);
                if (bus.RSP_STB) got = 1;
            end
            check("rst_norsp", got, 0);
            return;
        end
        got = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge CLK);
            if (bus.RSP_STB) begin
                got = 1;
                break;
            end
        end
        check("rsp_seen", got, 1);
        if (got) begin
            check("rsp_data", bus.RSP_DATA, exp_d);
            check("rsp_to", bus.RSP_TO, to);
            check("rsp_cs", bus.CS, 1);
            check("rsp_busy", bus.BUSY, 1);
            @(negedge CLK);
            check("busy_off", bus.BUSY, 0);
            check("rsp_pulse", bus.RSP_STB, 0);
            check("rsp_hold", bus.RSP_DATA, exp_d);
        end
        check("q_empty", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.CMD_STB    = 1'b0;
        bus.CMD_IDX    = '0;
        bus.CMD_ARG    = '0;
        bus.SPI_W_ACK  = 1'b0;
        bus.SPI_R_STB  = 1'b0;
        bus.SPI_R_DATA = 8'hFF;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_cs0", bus.CS, 1);
        check("rst_busy0", bus.BUSY, 0);
        check("rst_ack0", bus.CMD_ACK, 0);
        check("rst_rstb0", bus.RSP_STB, 0);
        check("rst_rdat0", bus.RSP_DATA, 8'h00);
        check("rst_to0", bus.RSP_TO, 0);
        check("rst_wstb0", bus.SPI_W_STB, 0);
        check("rst_wdat0", bus.SPI_W_DATA, 8'hFF);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        do_cmd(6'd0, 32'h0, 8'h95, 2, 8'h01, 0, 0, 0, 0);
        do_cmd(6'd8, 32'h0000_01AA, 8'h87, 1, 8'h01, 0, 1, 0, 0);
        do_cmd(6'd55, 32'h0, crc_of(6'd55, 32'h0), 0, 8'h00, 0, 1, 0, 0);
        do_cmd(6'd41, 32'h4000_0000, crc_of(6'd41, 32'h4000_0000),
               8, 8'h05, 0, 0, 0, 0);
        do_cmd(6'd17, 32'h1234_5678, crc_of(6'd17, 32'h1234_5678),
               3, 8'h00, 1, 1, 1, 0);
        do_cmd(6'd24, 32'hDEAD_BEEF, crc_of(6'd24, 32'hDEAD_BEEF),
               1, 8'h01, 0, 0, 0, 3);
        do_cmd(6'd0, 32'h0, 8'h95, 1, 8'h01, 1, 0, 0, 0);

        repeat (3) @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
